// File: rtl/mult_pipe_if.sv
// Issue/stall inputs and per-stage bypass outputs of the five-stage multiplier.
// master = core issue logic and bypass controller, slave = mult_pipe.
interface mult_pipe_if;
   logic        issue_valid_i;
   logic [1:0]  issue_op_i;
   logic [31:0] issue_rs1_i;
   logic [31:0] issue_rs2_i;
   logic [4:0]  issue_rd_i;
   logic        stall_i;

   logic [4:0]  mult1_addr_o;
   logic [4:0]  mult2_addr_o;
   logic [4:0]  mult3_addr_o;
   logic [4:0]  mult4_addr_o;
   logic [4:0]  mult5_addr_o;
   logic        mult1_wr_en_o;
   logic        mult2_wr_en_o;
   logic        mult3_wr_en_o;
   logic        mult4_wr_en_o;
   logic        mult5_wr_en_o;
   logic [31:0] mult5_data_o;
   logic        busy_o;

   modport master (
      output issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_rd_i, stall_i,
      input  mult1_addr_o, mult2_addr_o, mult3_addr_o, mult4_addr_o, mult5_addr_o,
      input  mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o,
      input  mult5_data_o, busy_o
   );

   modport slave (
      input  issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_rd_i, stall_i,
      output mult1_addr_o, mult2_addr_o, mult3_addr_o, mult4_addr_o, mult5_addr_o,
      output mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o,
      output mult5_data_o, busy_o
   );
endinterface

// File: rtl/mult_pipe.sv
// Five-stage RV32M multiplier: 33x11 slice products accumulate over M1..M4,
// M5 registers the selected 32-bit result for write-back.
module mult_pipe (
   input  logic       clk_i,
   input  logic       rst_i,
   mult_pipe_if.slave bus
);
   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } op_e;

   // Each stage keeps only the slices of b that later stages still consume.
   typedef struct packed {
      logic        valid;
      op_e         op;
      logic [4:0]  rd;
      logic [32:0] a;
      logic [32:0] b;
      logic [65:0] acc;
   } m1_t;

   typedef struct packed {
      logic        valid;
      op_e         op;
      logic [4:0]  rd;
      logic [32:0] a;
      logic [21:0] b_hi;    // b[32:11]
      logic [65:0] acc;
   } m2_t;

   typedef struct packed {
      logic        valid;
      op_e         op;
      logic [4:0]  rd;
      logic [32:0] a;
      logic [10:0] b_top;   // b[32:22], carries the sign
      logic [65:0] acc;
   } m3_t;

   typedef struct packed {
      logic        valid;
      op_e         op;
      logic [4:0]  rd;
      logic [63:0] acc;
   } m4_t;

   m1_t m1, m1_nxt;
   m2_t m2, m2_nxt;
   m3_t m3, m3_nxt;
   m4_t m4, m4_nxt;
   logic        m5_valid, m5_valid_nxt;
   logic [4:0]  m5_rd, m5_rd_nxt;
   logic [31:0] m5_data, m5_data_nxt;

   logic [65:0] prod1, prod2, prod3;
   logic [65:0] acc3_full;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      m1_nxt       = '0;
      m2_nxt       = '0;
      m3_nxt       = '0;
      m4_nxt       = '0;
      m5_valid_nxt = 1'b0;
      m5_rd_nxt    = '0;
      m5_data_nxt  = '0;
      prod1        = '0;
      prod2        = '0;
      prod3        = '0;
      acc3_full    = '0;

      m1_nxt.valid = bus.issue_valid_i;
      m1_nxt.op    = op_e'(bus.issue_op_i);
      m1_nxt.rd    = bus.issue_rd_i;
      m1_nxt.a     = {(m1_nxt.op == OP_MULH || m1_nxt.op == OP_MULHSU) & bus.issue_rs1_i[31],
                      bus.issue_rs1_i};
      m1_nxt.b     = {(m1_nxt.op == OP_MULH) & bus.issue_rs2_i[31], bus.issue_rs2_i};

      // Modulo-2^66 products of the sign-extended a with each b slice.
      prod1 = {{33{m1.a[32]}}, m1.a} * {55'd0, m1.b[10:0]};
      m2_nxt.valid = m1.valid;
      m2_nxt.op    = m1.op;
      m2_nxt.rd    = m1.rd;
      m2_nxt.a     = m1.a;
      m2_nxt.b_hi  = m1.b[32:11];
      m2_nxt.acc   = m1.acc + prod1;

      prod2 = {{33{m2.a[32]}}, m2.a} * {55'd0, m2.b_hi[10:0]};
      m3_nxt.valid = m2.valid;
      m3_nxt.op    = m2.op;
      m3_nxt.rd    = m2.rd;
      m3_nxt.a     = m2.a;
      m3_nxt.b_top = m2.b_hi[21:11];
      m3_nxt.acc   = m2.acc + (prod2 << 11);

      prod3 = {{33{m3.a[32]}}, m3.a} * {{55{m3.b_top[10]}}, m3.b_top};
      acc3_full    = m3.acc + (prod3 << 22);
      m4_nxt.valid = m3.valid;
      m4_nxt.op    = m3.op;
      m4_nxt.rd    = m3.rd;
      m4_nxt.acc   = acc3_full[63:0];

      m5_valid_nxt = m4.valid;
      m5_rd_nxt    = m4.rd;
      m5_data_nxt  = (m4.op == OP_MUL) ? m4.acc[31:0] : m4.acc[63:32];
   end

   // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m1       <= '0;
         m2       <= '0;
         m3       <= '0;
         m4       <= '0;
         m5_valid <= 1'b0;
         m5_rd    <= '0;
         m5_data  <= '0;
      end else if (!bus.stall_i) begin
         m1       <= m1_nxt;
         m2       <= m2_nxt;
         m3       <= m3_nxt;
         m4       <= m4_nxt;
         m5_valid <= m5_valid_nxt;
         m5_rd    <= m5_rd_nxt;
         m5_data  <= m5_data_nxt;
      end
   end

   assign bus.mult1_addr_o  = m1.rd;
   assign bus.mult2_addr_o  = m2.rd;
   assign bus.mult3_addr_o  = m3.rd;
   assign bus.mult4_addr_o  = m4.rd;
   assign bus.mult5_addr_o  = m5_rd;
   assign bus.mult1_wr_en_o = m1.valid && (m1.rd != 5'd0);
   assign bus.mult2_wr_en_o = m2.valid && (m2.rd != 5'd0);
   assign bus.mult3_wr_en_o = m3.valid && (m3.rd != 5'd0);
   assign bus.mult4_wr_en_o = m4.valid && (m4.rd != 5'd0);
   assign bus.mult5_wr_en_o = m5_valid && (m5_rd != 5'd0);
   assign bus.mult5_data_o  = m5_data;
   assign bus.busy_o        = m1.valid | m2.valid | m3.valid | m4.valid | m5_valid;
endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: vector table for arithmetic, hand sequences
// for latency, stall, rd=0 and asynchronous reset behaviour.
module tb_mult_pipe;
   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   mult_pipe_if bus ();

   mult_pipe dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] wr_vec();
      return {bus.mult5_wr_en_o, bus.mult4_wr_en_o, bus.mult3_wr_en_o,
              bus.mult2_wr_en_o, bus.mult1_wr_en_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      bus.issue_valid_i = 1'b1;
      bus.issue_op_i    = op;
      bus.issue_rs1_i   = a;
      bus.issue_rs2_i   = b;
      bus.issue_rd_i    = rd;
   endtask

   task automatic idle();
      bus.issue_valid_i = 1'b0;
   endtask

   vec_t        vecs[15];
   logic [4:0]  got_rd[$];
   logic [31:0] got_data[$];

   task automatic tick_collect();
      logic st;
      st = bus.stall_i;
      tick();
      if (!st && bus.mult5_wr_en_o) begin
         got_rd.push_back(bus.mult5_addr_o);
         got_data.push_back(bus.mult5_data_o);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
      vecs[1]  = '{OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[4]  = '{OP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
      vecs[5]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[6]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[7]  = '{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[8]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[9]  = '{OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
      vecs[10] = '{OP_MULHU,  32'h0000_0800, 32'h0040_0000, 32'h0000_0002};
      vecs[11] = '{OP_MUL,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA};
      vecs[12] = '{OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
      vecs[13] = '{OP_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
      vecs[14] = '{OP_MULH,   32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF};

      rst = 1'b1;
      bus.stall_i       = 1'b0;
      bus.issue_valid_i = 1'b0;
      bus.issue_op_i    = OP_MUL;
      bus.issue_rs1_i   = '0;
      bus.issue_rs2_i   = '0;
      bus.issue_rd_i    = '0;

      // Reset state
      #2;
      check("reset_wr_en", {27'd0, wr_vec()}, 32'd0);
      check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
      check("reset_data", bus.mult5_data_o, 32'd0);
      check("reset_addr", {7'd0, bus.mult1_addr_o, bus.mult2_addr_o, bus.mult3_addr_o,
                           bus.mult4_addr_o, bus.mult5_addr_o}, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Single MUL rd=5: stage-by-stage latency
      issue(OP_MUL, 32'd7, 32'd6, 5'd5);
      tick();
      idle();
      check("single_m1_wr_en", {27'd0, wr_vec()}, 32'b00001);
      check("single_m1_addr", {27'd0, bus.mult1_addr_o}, 32'd5);
      tick();
      check("single_m2_wr_en", {27'd0, wr_vec()}, 32'b00010);
      check("single_m2_addr", {27'd0, bus.mult2_addr_o}, 32'd5);
      tick();
      tick();
      check("single_m4_wr_en", {27'd0, wr_vec()}, 32'b01000);
      tick();
      check("single_m5_wr_en", {27'd0, wr_vec()}, 32'b10000);
      check("single_m5_addr", {27'd0, bus.mult5_addr_o}, 32'd5);
      check("single_m5_data", bus.mult5_data_o, 32'd42);
      tick();
      check("single_drained_wr_en", {27'd0, wr_vec()}, 32'd0);
      check("single_drained_busy", {31'd0, bus.busy_o}, 32'd0);

      // Vector table
      for (int i = 0; i < 15; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
         tick();
         idle();
         tick();
         tick();
         tick();
         check($sformatf("vec%0d_not_early", i), {31'd0, bus.mult5_wr_en_o}, 32'd0);
         tick();
         check($sformatf("vec%0d_wr_en", i), {31'd0, bus.mult5_wr_en_o}, 32'd1);
         check($sformatf("vec%0d_data", i), bus.mult5_data_o, vecs[i].exp);
      end
      tick();

      // Back-to-back issue with a two-cycle stall mid-stream
      got_rd.delete();
      got_data.delete();
      for (int k = 1; k <= 3; k++) begin
         issue(OP_MUL, 32'(k), 32'd10, 5'(k));
         tick_collect();
      end
      bus.stall_i = 1'b1;
      issue(OP_MUL, 32'd4, 32'd10, 5'd4);
      for (int s = 0; s < 2; s++) begin
         tick_collect();
         check($sformatf("stall%0d_addrs", s),
               {17'd0, bus.mult1_addr_o, bus.mult2_addr_o, bus.mult3_addr_o},
               {17'd0, 5'd3, 5'd2, 5'd1});
         check($sformatf("stall%0d_wr_en", s), {27'd0, wr_vec()}, 32'b00111);
      end
      bus.stall_i = 1'b0;
      tick_collect();
      check("resume_addrs",
            {12'd0, bus.mult1_addr_o, bus.mult2_addr_o, bus.mult3_addr_o, bus.mult4_addr_o},
            {12'd0, 5'd4, 5'd3, 5'd2, 5'd1});
      issue(OP_MUL, 32'd5, 32'd10, 5'd5);
      tick_collect();
      idle();
      for (int c = 0; c < 12 && got_rd.size() < 5; c++) tick_collect();
      for (int c = 0; c < 3; c++) tick_collect();
      check("b2b_result_count", 32'(got_rd.size()), 32'd5);
      for (int k = 0; k < 5 && k < got_rd.size(); k++) begin
         check($sformatf("b2b%0d_rd", k), {27'd0, got_rd[k]}, 32'(k + 1));
         check($sformatf("b2b%0d_data", k), got_data[k], 32'((k + 1) * 10));
      end

      // rd=0 op: busy for five cycles, never a write enable
      issue(OP_MUL, 32'd3, 32'd3, 5'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         idle();
         check($sformatf("rd0_busy%0d", c), {31'd0, bus.busy_o}, 32'd1);
         check($sformatf("rd0_wr_en%0d", c), {27'd0, wr_vec()}, 32'd0);
      end
      check("rd0_data", bus.mult5_data_o, 32'd9);
      tick();
      check("rd0_idle_busy", {31'd0, bus.busy_o}, 32'd0);

      // Asynchronous reset with three ops in flight
      for (int k = 0; k < 3; k++) begin
         issue(OP_MUL, 32'd11, 32'd11, 5'(7 + k));
         tick();
      end
      idle();
      check("pre_reset_busy", {31'd0, bus.busy_o}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_wr_en", {27'd0, wr_vec()}, 32'd0);
      check("async_reset_busy", {31'd0, bus.busy_o}, 32'd0);
      check("async_reset_data", bus.mult5_data_o, 32'd0);
      #1;
      rst = 1'b0;
      issue(OP_MUL, 32'd2, 32'd2, 5'd6);
      tick();
      idle();
      check("post_reset_capture", {27'd0, wr_vec()}, 32'b00001);
      check("post_reset_addr", {27'd0, bus.mult1_addr_o}, 32'd6);
      tick();
      tick();
      tick();
      tick();
      check("post_reset_data", bus.mult5_data_o, 32'd4);
      check("post_reset_m5_wr_en", {27'd0, wr_vec()}, 32'b10000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
